// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: RV64I multicycle control sequencer with memory wait states, exception path and halt; define OVERFLOW_EXC_EN to trap on ALU overflow
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               alu_overflow,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_funct,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               load_a,
  output logic               load_b,
  output logic               load_alu_out,
  output logic               load_ir,
  output logic               load_mdr,
  output logic               reg_write,
  output logic [2:0]         mem_to_reg,
  output logic               dmem_write,
  output logic [1:0]         size,
  output logic [1:0]         branch_op,
  output logic [1:0]         shift_ctrl,
  output logic               load_epc,
  output logic               exc_valid,
  output logic [1:0]         exc_cause,
  output logic               halted,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [4:0] {
    FETCH = 5'd0, DECODE, ADDR, EXEC_R, EXEC_I, ALU_WB, MEM_RD, LD_WB, MEM_WR,
    LUI, BRANCH, BR_WAIT, JAL_LINK, JAL_JUMP, SHIFT, SLT, EXC, HALT
  } st_t;
  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);
  st_t st, nxt;
  logic [3:0] cnt, nxt_cnt;
  logic [1:0] nxt_cause;
  logic nlast, ovf, unused_bits;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [5:0] hi6;
  assign op = instruction[6:0];
  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];
  assign hi6 = instruction[31:26];
  assign nlast = nxt_cnt == LAST;
  assign state = STATE_W'(st);
`ifdef OVERFLOW_EXC_EN
  assign ovf = alu_overflow;
  assign unused_bits = ^instruction[24:15];
`else
  assign ovf = 1'b0;
  assign unused_bits = ^{alu_overflow, instruction[24:15]};
`endif
  always_comb begin
    nxt = st;
    nxt_cnt = 4'd0;
    nxt_cause = 2'b01;
    case (st)
      FETCH, MEM_RD, MEM_WR: begin
        nxt_cnt = cnt == LAST ? 4'd0 : cnt + 4'd1;
        nxt = cnt != LAST ? st : st == FETCH ? DECODE : st == MEM_RD ? LD_WB : FETCH;
      end
      DECODE: case (op)
        7'b0110011: nxt = f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111) ? EXEC_R :
                          f7 == 7'b0000000 && f3 == 3'b010 ? SLT :
                          f7 == 7'b0100000 && f3 == 3'b000 ? EXEC_R : EXC;
        7'b0010011: nxt = instruction[11:7] == 5'd0 ? FETCH :
                          f3 == 3'b000 ? EXEC_I :
                          (f3 == 3'b001 && hi6 == 6'b000000) ||
                          (f3 == 3'b101 && (hi6 == 6'b000000 || hi6 == 6'b010000)) ? SHIFT :
                          f3 == 3'b010 ? SLT : EXC;
        7'b0000011, 7'b0100011: nxt = ADDR;
        7'b0110111: nxt = LUI;
        7'b1100011: nxt = BRANCH;
        7'b1100111: nxt = f3 == 3'b001 || f3 == 3'b101 || f3 == 3'b100 ? BRANCH : EXC;
        7'b1101111: nxt = JAL_LINK;
        7'b1110011: nxt = HALT;
        default: begin
          nxt = EXC;
          nxt_cause = 2'b00;
        end
      endcase
      ADDR: nxt = !op[5] ? MEM_RD : !f3[2] ? MEM_WR : EXC;
      EXEC_R: begin
        nxt = ovf && f3 == 3'b000 ? EXC : ALU_WB;
        nxt_cause = 2'b10;
      end
      EXEC_I: begin
        nxt = ovf ? EXC : ALU_WB;
        nxt_cause = 2'b10;
      end
      BRANCH, JAL_JUMP: nxt = BR_WAIT;
      JAL_LINK: nxt = JAL_JUMP;
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      cnt <= 4'd0;
      pc_write <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_src <= 2'b00;
      alu_funct <= 3'b000;
      alu_src_a <= 1'b0;
      alu_src_b <= 2'b00;
      load_a <= 1'b0;
      load_b <= 1'b0;
      load_alu_out <= 1'b0;
      load_ir <= 1'b0;
      load_mdr <= 1'b0;
      reg_write <= 1'b0;
      mem_to_reg <= 3'b000;
      dmem_write <= 1'b0;
      size <= 2'b00;
      branch_op <= 2'b00;
      shift_ctrl <= 2'b00;
      load_epc <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= 2'b00;
      halted <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt_cnt;
      pc_write <= (nxt == FETCH && nlast) || nxt == JAL_JUMP || nxt == EXC;
      pc_write_cond <= nxt == BRANCH;
      pc_src <= nxt == EXC ? 2'b10 : nxt == BRANCH || nxt == JAL_JUMP ? 2'b01 : 2'b00;
      alu_funct <= nxt == EXEC_R ? (f3 == 3'b111 ? 3'b011 : f7[5] ? 3'b010 : 3'b001) :
                   nxt == BRANCH || nxt == SLT ? 3'b010 :
                   nxt inside {FETCH, DECODE, EXEC_I, ADDR} ? 3'b001 : 3'b000;
      alu_src_a <= nxt inside {EXEC_R, EXEC_I, ADDR, SLT, BRANCH};
      alu_src_b <= nxt == FETCH ? 2'b01 : nxt == DECODE ? 2'b11 :
                   nxt == EXEC_I || nxt == ADDR || (nxt == SLT && !op[5]) ? 2'b10 : 2'b00;
      load_a <= nxt == DECODE;
      load_b <= nxt == DECODE;
      load_alu_out <= nxt inside {DECODE, EXEC_R, EXEC_I, ADDR};
      load_ir <= nxt == FETCH && nlast;
      load_mdr <= nxt == MEM_RD && nlast;
      reg_write <= nxt inside {ALU_WB, SLT, SHIFT, LD_WB, LUI, JAL_LINK};
      mem_to_reg <= nxt == LD_WB ? 3'b001 : nxt == LUI ? 3'b010 : nxt == JAL_LINK ? 3'b011 :
                    nxt == SHIFT ? 3'b100 : nxt == SLT ? 3'b101 : 3'b000;
      dmem_write <= nxt == MEM_WR && nlast;
      size <= nxt == MEM_WR ? ~f3[1:0] : 2'b00;
      branch_op <= nxt != BRANCH ? 2'b00 : f3 == 3'b001 ? 2'b01 : f3 == 3'b101 ? 2'b10 :
                   f3 == 3'b100 ? 2'b11 : 2'b00;
      shift_ctrl <= nxt != SHIFT || !f3[2] ? 2'b00 : instruction[30] ? 2'b10 : 2'b01;
      load_epc <= nxt == EXC;
      exc_valid <= nxt == EXC;
      halted <= nxt == HALT;
      if (nxt == EXC) exc_cause <= nxt_cause;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: cycle-by-cycle model check of the multicycle control sequencer
module tb_multicycle_ctrl_fsm;
  localparam int MW = 3;
`ifdef OVERFLOW_EXC_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  typedef struct packed {
    logic [4:0] st;
    logic pcw, pcwc;
    logic [1:0] pcs;
    logic [2:0] af;
    logic asa;
    logic [1:0] asb;
    logic la, lb, lao, lir, lmdr, rw;
    logic [2:0] m2r;
    logic dw;
    logic [1:0] sz, bop, sh;
    logic lepc, ev;
    logic [1:0] cause;
    logic h;
  } cyc_t;
  logic clk = 1'b0, reset = 1'b1, alu_overflow = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic pc_write, pc_write_cond, alu_src_a, load_a, load_b, load_alu_out, load_ir, load_mdr;
  logic reg_write, dmem_write, load_epc, exc_valid, halted;
  logic [1:0] pc_src, alu_src_b, size, branch_op, shift_ctrl, exc_cause;
  logic [2:0] alu_funct, mem_to_reg;
  logic [4:0] state;
  cyc_t act, exp_c;
  cyc_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [1:0] m_cause = 2'b00;
  bit post_reset = 1'b0, watch = 1'b0, dw_seen = 1'b0;
  logic [32:0] tab [24] = '{
    {1'b1, 32'h00108093}, {1'b0, 32'h00108093}, {1'b1, 32'h003100B3}, {1'b0, 32'h403100B3},
    {1'b1, 32'h003170B3}, {1'b0, 32'h003120B3}, {1'b0, 32'h0020A093}, {1'b0, 32'h00309093},
    {1'b0, 32'h0030D093}, {1'b0, 32'h4030D093}, {1'b0, 32'h0000A083}, {1'b0, 32'h000010B7},
    {1'b0, 32'h008000EF}, {1'b0, 32'h00000013}, {1'b0, 32'h023100B3}, {1'b0, 32'h00114223},
    {1'b0, 32'h00008067}, {1'b0, 32'h0000D067}, {1'b0, 32'h00110223}, {1'b0, 32'h00113223},
    {1'b0, 32'h00111223}, {1'b0, 32'h0020C063}, {1'b0, 32'h00007093}, {1'b0, 32'h40309093}
  };
  multicycle_ctrl_fsm #(.MEM_WAIT(MW), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_overflow(alu_overflow),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_funct(alu_funct),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .load_a(load_a), .load_b(load_b),
    .load_alu_out(load_alu_out), .load_ir(load_ir), .load_mdr(load_mdr), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .dmem_write(dmem_write), .size(size), .branch_op(branch_op),
    .shift_ctrl(shift_ctrl), .load_epc(load_epc), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .halted(halted), .state(state)
  );
  assign act = {state, pc_write, pc_write_cond, pc_src, alu_funct, alu_src_a, alu_src_b, load_a,
                load_b, load_alu_out, load_ir, load_mdr, reg_write, mem_to_reg, dmem_write, size,
                branch_op, shift_ctrl, load_epc, exc_valid, exc_cause, halted};
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_c = q.pop_front();
      check($sformatf("cycle st%0d ir=%h", exp_c.st, instruction), 64'(act), 64'(exp_c));
    end
    if (watch && dmem_write) dw_seen = 1'b1;
  end
  task automatic emit(input cyc_t c);
    c.cause = m_cause;
    q.push_back(c);
  endtask
  task automatic plan(input logic [31:0] i, input bit o);
    cyc_t c;
    int nx;
    logic [1:0] cz;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    for (int k = 0; k < MW; k++) begin
      c = '0;
      if (!(post_reset && k == 0)) begin
        c.asb = 2'b01;
        c.af = 3'b001;
        c.pcw = k == MW - 1;
        c.lir = k == MW - 1;
      end
      emit(c);
    end
    post_reset = 1'b0;
    c = '0;
    c.st = 5'd1;
    c.la = 1'b1;
    c.lb = 1'b1;
    c.lao = 1'b1;
    c.asb = 2'b11;
    c.af = 3'b001;
    emit(c);
    nx = 16;
    cz = 2'b01;
    case (op)
      7'h33: if (f7 == 7'h00 && (f3 == 0 || f3 == 7)) nx = 3;
             else if (f7 == 7'h00 && f3 == 2) nx = 15;
             else if (f7 == 7'h20 && f3 == 0) nx = 3;
      7'h13: if (i[11:7] == 0) nx = 0;
             else if (f3 == 0) nx = 4;
             else if (f3 == 1 && i[31:26] == 0) nx = 14;
             else if (f3 == 5 && (i[31:26] == 0 || i[31:26] == 6'h10)) nx = 14;
             else if (f3 == 2) nx = 15;
      7'h03, 7'h23: nx = 2;
      7'h37: nx = 9;
      7'h63: nx = 10;
      7'h67: if (f3 == 1 || f3 == 5 || f3 == 4) nx = 10;
      7'h6F: nx = 12;
      7'h73: nx = 17;
      default: cz = 2'b00;
    endcase
    while (nx != 0) begin
      c = '0;
      c.st = 5'(nx);
      case (nx)
        2: begin
          c.asa = 1; c.asb = 2'b10; c.af = 3'b001; c.lao = 1; emit(c);
          if (op == 7'h03) nx = 6;
          else if (f3 < 4) nx = 8;
          else begin nx = 16; cz = 2'b01; end
        end
        3: begin
          c.asa = 1; c.lao = 1; c.af = f3 == 7 ? 3'b011 : f7 == 7'h20 ? 3'b010 : 3'b001; emit(c);
          if (OVF && o && f3 == 0) begin nx = 16; cz = 2'b10; end else nx = 5;
        end
        4: begin
          c.asa = 1; c.asb = 2'b10; c.af = 3'b001; c.lao = 1; emit(c);
          if (OVF && o) begin nx = 16; cz = 2'b10; end else nx = 5;
        end
        5: begin c.rw = 1; emit(c); nx = 0; end
        6: begin
          for (int k = 0; k < MW; k++) begin c.lmdr = k == MW - 1; emit(c); end
          nx = 7;
        end
        7: begin c.rw = 1; c.m2r = 3'b001; emit(c); nx = 0; end
        8: begin
          c.sz = 2'(3 - int'(f3));
          for (int k = 0; k < MW; k++) begin c.dw = k == MW - 1; emit(c); end
          nx = 0;
        end
        9: begin c.rw = 1; c.m2r = 3'b010; emit(c); nx = 0; end
        10: begin
          c.asa = 1; c.af = 3'b010; c.pcwc = 1; c.pcs = 2'b01;
          c.bop = f3 == 1 ? 2'b01 : f3 == 5 ? 2'b10 : f3 == 4 ? 2'b11 : 2'b00;
          emit(c); nx = 11;
        end
        11: begin emit(c); nx = 0; end
        12: begin c.rw = 1; c.m2r = 3'b011; emit(c); nx = 13; end
        13: begin c.pcw = 1; c.pcs = 2'b01; emit(c); nx = 11; end
        14: begin
          c.rw = 1; c.m2r = 3'b100; c.sh = f3 == 1 ? 2'b00 : i[30] ? 2'b10 : 2'b01;
          emit(c); nx = 0;
        end
        15: begin
          c.asa = 1; c.af = 3'b010; c.m2r = 3'b101; c.rw = 1; c.asb = op == 7'h13 ? 2'b10 : 2'b00;
          emit(c); nx = 0;
        end
        16: begin
          m_cause = cz; c.ev = 1; c.lepc = 1; c.pcw = 1; c.pcs = 2'b10; emit(c); nx = 0;
        end
        default: begin
          c.h = 1; repeat (4) emit(c); nx = 0;
        end
      endcase
    end
  endtask
  task automatic drain();
    for (int n = 0; q.size() != 0; n++) begin
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain timeout: %0d cycles pending, expected 0", q.size());
        q.delete();
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic run(input logic [31:0] i, input bit o);
    instruction = i;
    alu_overflow = o;
    plan(i, o);
    drain();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_cause = 2'b00;
    post_reset = 1'b1;
  endtask
  initial begin
    do_reset();
    check("reset state", 64'(state), 64'd0);
    check("reset outputs", 64'(act), 64'd0);
    instruction = 32'h003100B3;
    plan(instruction, 1'b0);
    check("add length", 64'(q.size()), 64'd6);
    check("add first fetch", 64'(q[0]), 64'd0);
    check("add exec_r funct", 64'(q[4].af), 64'd1);
    check("add wb reg_write", 64'(q[5].rw), 64'd1);
    drain();
    instruction = 32'h00112223;
    plan(instruction, 1'b0);
    check("sw length", 64'(q.size()), 64'd8);
    check("sw size", 64'(q[5].sz), 64'd1);
    check("sw early dmem_write", 64'(q[5].dw), 64'd0);
    check("sw last dmem_write", 64'(q[7].dw), 64'd1);
    drain();
    instruction = 32'h0000007F;
    plan(instruction, 1'b0);
    check("exc length", 64'(q.size()), 64'd5);
    check("exc cause", 64'(q[4].cause), 64'd0);
    check("exc pc_src", 64'(q[4].pcs), 64'd2);
    drain();
    instruction = 32'h00209463;
    plan(instruction, 1'b0);
    check("bne branch_op", 64'(q[4].bop), 64'd1);
    check("bne length", 64'(q.size()), 64'd6);
    drain();
    foreach (tab[k]) run(tab[k][31:0], tab[k][32]);
    instruction = 32'h00112223;
    alu_overflow = 1'b0;
    for (int n = 0; state != 5'd8; n++) begin
      if (n > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL reach MEM_WR: state %0d expected 8", state);
        break;
      end
      @(posedge clk);
      #1;
    end
    dw_seen = 1'b0;
    watch = 1'b1;
    do_reset();
    watch = 1'b0;
    check("dmem_write under reset", 64'(dw_seen), 64'd0);
    check("post reset state", 64'(state), 64'd0);
    check("post reset outputs", 64'(act), 64'd0);
    run(32'h003100B3, 1'b0);
    run(32'h00100073, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("halted sticky", 64'(halted), 64'd1);
    check("halt state", 64'(state), 64'd17);
    do_reset();
    run(32'h0000A083, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
